// File: rtl/imem_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_pkg
// Shared definitions for the instruction-memory boot loader: the frame sync
// byte, the loader state encodings (also imported by the bench) and a small
// helper that decides whether a received word count fits the memory.
// -----------------------------------------------------------------------------
package imem_boot_loader_pkg;

  // First byte of every boot frame; anything else is discarded while idle.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Loader state encodings, in frame order. DONE and ERR are terminal.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } boot_state_t;

  // A length is usable when it is non-zero and no larger than the memory depth.
  function automatic logic len_ok(input logic [15:0] n, input int aw);
    logic [31:0] depth;
    depth = 32'd1 << aw;
    return (n != 16'd0) && ({16'd0, n} <= depth);
  endfunction

endpackage

// File: rtl/imem_boot_loader_word_packer.sv
// -----------------------------------------------------------------------------
// word_packer
// Assembles four consecutive bytes into one little-endian 32-bit word.
// The first byte of a word lands in bits [7:0], the fourth in bits [31:24].
// word_ready/word_data are combinational so the parent can register the
// finished word on the same edge that accepts its fourth byte.
//
// Ports:
//   clk         in   rising-edge clock
//   areset      in   synchronous active-high reset
//   clear       in   drops any partially assembled word (synchronous)
//   byte_valid  in   a byte is being accepted this cycle
//   byte_data   in   the byte being accepted
//   word_ready  out  this byte completes a word
//   word_data   out  the completed word (valid while word_ready is high)
// -----------------------------------------------------------------------------
module word_packer (
  input  logic        clk,
  input  logic        areset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_ready,
  output logic [31:0] word_data
);

  logic [1:0]  lane;
  logic [23:0] shreg;

  // The three earlier bytes sit in shreg with the oldest in the low lane, so
  // the incoming fourth byte simply goes on top.
  assign word_ready = byte_valid && (lane == 2'd3);
  assign word_data  = {byte_data, shreg};

  // Lane counter and shift register; shifting right keeps the oldest byte in
  // the low lane once three bytes have arrived.
  always_ff @(posedge clk) begin
    if (areset || clear) begin
      lane  <= 2'd0;
      shreg <= 24'd0;
    end else if (byte_valid) begin
      lane  <= lane + 2'd1;
      shreg <= {byte_data, shreg[23:8]};
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Streams a program image from a byte-wide valid/ready source into the core's
// instruction memory and holds the core in reset until the whole image has been
// written and its XOR checksum matches.
//
// Frame: A5 | N[7:0] | N[15:8] | 4*N data bytes (little-endian words) | CSUM
//
// Ports:
//   clk           in   rising-edge clock
//   areset        in   synchronous active-high reset, beats every other event
//   rx_data       in   incoming byte
//   rx_valid      in   rx_data valid
//   rx_ready      out  loader can accept (byte taken on rx_valid & rx_ready)
//   imem_we       out  one-cycle instruction-memory write strobe
//   imem_addr     out  word address of the write
//   imem_wdata    out  assembled instruction word
//   core_rst      out  active-high core reset, released only on a good load
//   done          out  load complete and checksum OK (sticky)
//   error         out  load failed (sticky until areset)
//   words_loaded  out  words written in the current frame
// -----------------------------------------------------------------------------
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int IMEM_AW        = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               areset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               core_rst,
  output logic               done,
  output logic               error,
  output logic [IMEM_AW:0]   words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  boot_state_t       state;
  logic [7:0]        len_lo;
  logic [15:0]       word_total;
  logic [IMEM_AW:0]  word_cnt;
  logic [IMEM_AW:0]  word_next;
  logic [7:0]        csum;
  logic [TW-1:0]     idle_cnt;
  logic              accept;
  logic              active;
  logic              timeout_hit;
  logic              word_ready;
  logic [31:0]       word_data;
  logic [15:0]       len_rx;

  assign accept    = rx_valid && rx_ready;
  assign active    = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                     (state == ST_DATA)   || (state == ST_CSUM);
  assign word_next = word_cnt + 1'b1;
  assign len_rx    = {rx_data, len_lo};

  // The idle counter holds the number of non-accept cycles already seen, so a
  // further idle cycle at TIMEOUT_CYCLES-1 is the one that expires.
  assign timeout_hit = active && !accept && (idle_cnt == TO_LAST);

  // The packer only sees bytes accepted in DATA and is cleared everywhere else,
  // so a partial word never survives a reset or a state change.
  word_packer u_packer (
    .clk        (clk),
    .areset     (areset),
    .clear      (state != ST_DATA),
    .byte_valid (accept && (state == ST_DATA)),
    .byte_data  (rx_data),
    .word_ready (word_ready),
    .word_data  (word_data)
  );

  // Loader FSM with registered outputs, plus the checksum, word counter and
  // idle-timeout counter. Terminal states drop rx_ready and never leave
  // without areset.
  always_ff @(posedge clk) begin
    if (areset) begin
      state        <= ST_IDLE;
      rx_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      core_rst     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len_lo       <= 8'd0;
      word_total   <= 16'd0;
      word_cnt     <= '0;
      csum         <= 8'd0;
      idle_cnt     <= '0;
    end else begin
      imem_we <= 1'b0;

      if (!active || accept) begin
        idle_cnt <= '0;
      end else if (idle_cnt != TO_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (timeout_hit) begin
        state    <= ST_ERR;
        rx_ready <= 1'b0;
        error    <= 1'b1;
        core_rst <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            rx_ready <= 1'b1;
            if (accept && (rx_data == SYNC_BYTE)) begin
              state <= ST_LEN_LO;
            end
          end

          ST_LEN_LO: begin
            if (accept) begin
              len_lo <= rx_data;
              state  <= ST_LEN_HI;
            end
          end

          ST_LEN_HI: begin
            if (accept) begin
              word_total   <= len_rx;
              word_cnt     <= '0;
              words_loaded <= '0;
              csum         <= 8'd0;
              if (len_ok(len_rx, IMEM_AW)) begin
                state <= ST_DATA;
              end else begin
                state    <= ST_ERR;
                rx_ready <= 1'b0;
                error    <= 1'b1;
                core_rst <= 1'b1;
              end
            end
          end

          ST_DATA: begin
            if (accept) begin
              csum <= csum ^ rx_data;
              if (word_ready) begin
                imem_we      <= 1'b1;
                imem_addr    <= word_cnt[IMEM_AW-1:0];
                imem_wdata   <= word_data;
                word_cnt     <= word_next;
                words_loaded <= word_next;
                if (16'(word_next) == word_total) begin
                  state <= ST_CSUM;
                end
              end
            end
          end

          ST_CSUM: begin
            if (accept) begin
              rx_ready <= 1'b0;
              if (rx_data == csum) begin
                state    <= ST_DONE;
                done     <= 1'b1;
                core_rst <= 1'b0;
              end else begin
                state    <= ST_ERR;
                error    <= 1'b1;
                core_rst <= 1'b1;
              end
            end
          end

          ST_DONE: begin
            rx_ready <= 1'b0;
            done     <= 1'b1;
            core_rst <= 1'b0;
          end

          ST_ERR: begin
            rx_ready <= 1'b0;
            error    <= 1'b1;
            core_rst <= 1'b1;
          end

          default: begin
            state    <= ST_ERR;
            rx_ready <= 1'b0;
            error    <= 1'b1;
            core_rst <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
// Directed bench for the boot loader: good load, bad checksum, leading
// garbage, bad lengths, idle timeout boundary and reset in the middle of a
// load. Writes to instruction memory are captured on the falling edge.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  localparam int AW = 8;

  logic          clk;
  logic          areset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  int checks;
  int errors;
  int we_count;
  int we_double;
  logic we_prev;
  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];

  logic [7:0] good_frame [0:11] = '{SYNC_BYTE, 8'h02, 8'h00,
                                    8'h93, 8'h00, 8'h50, 8'h00,
                                    8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};

  imem_boot_loader #(.IMEM_AW(AW), .TIMEOUT_CYCLES(1023)) dut (
    .clk          (clk),
    .areset       (areset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst     (core_rst),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every write strobe and flag any strobe longer than one cycle.
  initial begin
    we_count  = 0;
    we_double = 0;
    we_prev   = 1'b0;
  end
  always @(negedge clk) begin
    if (imem_we) begin
      if (we_count < 8) begin
        wr_addr[we_count] = 32'(imem_addr);
        wr_data[we_count] = imem_wdata;
      end
      we_count++;
      if (we_prev) we_double++;
    end
    we_prev = imem_we;
  end

  // Global guard so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Hold rx_valid low for n cycles; returns #1 after the last edge.
  task automatic idleCycles(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one byte after a gap and hold it until the edge that takes it.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waited;
    idleCycles(gap);
    rx_data  = b;
    rx_valid = 1'b1;
    waited   = 0;
    while (!rx_ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!rx_ready) begin
      checkOutput("ready_wait", 32'(rx_ready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic sendGoodFrame(input logic [7:0] last_byte);
    for (int i = 0; i < 12; i++) begin
      applyStimulus((i == 11) ? last_byte : good_frame[i], int'($urandom_range(0, 3)));
    end
  endtask

  task automatic doReset();
    areset   = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    areset   = 1'b0;
    we_count = 0;
  endtask

  task automatic checkGoodLoad(input string tag, input int writes);
    checkOutput({tag, "_we_count"}, 32'(we_count), 32'(writes));
    checkOutput({tag, "_addr0"}, wr_addr[writes-2], 32'd0);
    checkOutput({tag, "_data0"}, wr_data[writes-2], 32'h00500093);
    checkOutput({tag, "_addr1"}, wr_addr[writes-1], 32'd1);
    checkOutput({tag, "_data1"}, wr_data[writes-1], 32'h00100113);
    checkOutput({tag, "_words"}, 32'(words_loaded), 32'd2);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_core_rst"}, 32'(core_rst), 32'd0);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
    checkOutput({tag, "_ready"}, 32'(rx_ready), 32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    areset   = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wr_addr[i] = 32'hFFFF_FFFF;
      wr_data[i] = 32'hFFFF_FFFF;
    end

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(rx_ready), 32'd0);
    checkOutput("rst_we", 32'(imem_we), 32'd0);
    checkOutput("rst_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_wdata", imem_wdata, 32'd0);
    checkOutput("rst_core_rst", 32'(core_rst), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_words", 32'(words_loaded), 32'd0);
    areset   = 1'b0;
    we_count = 0;
    @(posedge clk);
    #1;
    checkOutput("idle_ready", 32'(rx_ready), 32'd1);

    // Test 1: normal load
    sendGoodFrame(8'hC1);
    checkGoodLoad("t1", 2);

    // Test 2: bad checksum, then rx_valid held high
    doReset();
    sendGoodFrame(8'hC0);
    checkOutput("t2_error", 32'(error), 32'd1);
    checkOutput("t2_core_rst", 32'(core_rst), 32'd1);
    checkOutput("t2_done", 32'(done), 32'd0);
    checkOutput("t2_ready", 32'(rx_ready), 32'd0);
    rx_data  = SYNC_BYTE;
    rx_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    checkOutput("t2_we_count", 32'(we_count), 32'd2);
    checkOutput("t2_error_hold", 32'(error), 32'd1);
    checkOutput("t2_done_hold", 32'(done), 32'd0);

    // Test 3: garbage before the frame
    doReset();
    applyStimulus(8'h00, 1);
    applyStimulus(8'hFF, 0);
    applyStimulus(8'h5A, 2);
    sendGoodFrame(8'hC1);
    checkGoodLoad("t3", 2);

    // Test 4: zero length, oversize length, largest legal length
    doReset();
    applyStimulus(SYNC_BYTE, 0);
    applyStimulus(8'h00, 1);
    applyStimulus(8'h00, 0);
    checkOutput("t4_zero_error", 32'(error), 32'd1);
    checkOutput("t4_zero_ready", 32'(rx_ready), 32'd0);
    checkOutput("t4_zero_we", 32'(we_count), 32'd0);
    doReset();
    applyStimulus(SYNC_BYTE, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h01, 0);
    checkOutput("t4_257_error", 32'(error), 32'd1);
    checkOutput("t4_257_core_rst", 32'(core_rst), 32'd1);
    doReset();
    applyStimulus(SYNC_BYTE, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    checkOutput("t4_256_error", 32'(error), 32'd0);
    checkOutput("t4_256_ready", 32'(rx_ready), 32'd1);

    // Test 5: idle timeout boundary in the middle of a word
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(good_frame[i], 0);
    idleCycles(1022);
    checkOutput("t5_1022_error", 32'(error), 32'd0);
    for (int i = 5; i < 12; i++) applyStimulus(good_frame[i], 0);
    checkGoodLoad("t5", 2);
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(good_frame[i], 0);
    idleCycles(1022);
    checkOutput("t5_pre_error", 32'(error), 32'd0);
    idleCycles(1);
    checkOutput("t5_1023_error", 32'(error), 32'd1);
    checkOutput("t5_1023_ready", 32'(rx_ready), 32'd0);
    checkOutput("t5_1023_we", 32'(we_count), 32'd0);

    // Test 6: reset one cycle after the fifth data byte, then reload
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(good_frame[i], int'($urandom_range(0, 2)));
    checkOutput("t6_mid_words", 32'(words_loaded), 32'd1);
    idleCycles(1);
    areset = 1'b1;
    @(posedge clk);
    #1;
    areset = 1'b0;
    checkOutput("t6_rst_words", 32'(words_loaded), 32'd0);
    checkOutput("t6_rst_core_rst", 32'(core_rst), 32'd1);
    checkOutput("t6_rst_done", 32'(done), 32'd0);
    checkOutput("t6_rst_we", 32'(we_count), 32'd1);
    sendGoodFrame(8'hC1);
    checkGoodLoad("t6", 3);

    checkOutput("we_single_cycle", 32'(we_double), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
